conv2d_window_scheduler: RTL and testbench

//  Raster-scan sequencer for the conv2d line buffer and window extractor; one frame per start pulse.

---
 rtl/conv2d_window_scheduler_if.sv | 27 ++
 rtl/conv2d_window_scheduler.sv | 108 ++++++++++
 tb/tb_conv2d_window_scheduler.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/conv2d_window_scheduler_if.sv
// Pixel-stream / window handshake bundle between the conv2d window scheduler and its neighbours.
// slave: the scheduler side; master: the frame controller / source / consumer side.
interface conv2d_window_scheduler_if #(
    parameter int CW = 3,
    parameter int RW = 3
);
    logic          start;
    logic          busy;
    logic          in_valid;
    logic          in_ready;
    logic          lb_shift_en;
    logic          window_valid;
    logic          win_ready;
    logic [RW-1:0] win_row;
    logic [CW-1:0] win_col;
    logic          frame_done;

    modport slave (
        input  start, in_valid, win_ready,
        output busy, in_ready, lb_shift_en, window_valid, win_row, win_col, frame_done
    );

    modport master (
        output start, in_valid, win_ready,
        input  busy, in_ready, lb_shift_en, window_valid, win_row, win_col, frame_done
    );
endinterface

// File: rtl/conv2d_window_scheduler.sv
// Raster-scan sequencer for the conv2d line buffer: counts accepted pixels, flags stride-aligned
// full 3x3 windows one cycle after the qualifying pixel, and stalls the source under backpressure.
module conv2d_window_scheduler #(
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 6,
    parameter int KERNEL = 3,
    parameter int STRIDE = 1,
    localparam int CW = $clog2(IMG_W),
    localparam int RW = $clog2(IMG_H),
    localparam int PW = (STRIDE > 1) ? $clog2(STRIDE) : 1
) (
    input  logic clk,
    input  logic rst_n,
    conv2d_window_scheduler_if.slave bus
);
    typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] col_q, cidx_q, win_col_q;
    logic [RW-1:0] row_q, ridx_q, win_row_q;
    logic [PW-1:0] col_ph_q, row_ph_q;
    logic          wv_q;

    logic in_ready, acc, col_last, row_last, col_in, row_in, qual;

    assign in_ready = (state_q == STREAM) & ~(wv_q & ~bus.win_ready);
    assign acc      = bus.in_valid & in_ready;
    assign col_last = (col_q == CW'(IMG_W - 1));
    assign row_last = (row_q == RW'(IMG_H - 1));
    assign col_in   = (col_q >= CW'(KERNEL - 1));
    assign row_in   = (row_q >= RW'(KERNEL - 1));
    // Phase counters start at zero on the first in-kernel row/col, so phase 0 means stride-aligned.
    assign qual     = acc & col_in & row_in & (col_ph_q == '0) & (row_ph_q == '0);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = STREAM;
            STREAM:  if (acc & col_last & row_last) state_d = DRAIN;
            // Last window either already gone, or being accepted now.
            DRAIN:   if (~wv_q | bus.win_ready) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q <= '0; cidx_q <= '0; col_ph_q <= '0;
            row_q <= '0; ridx_q <= '0; row_ph_q <= '0;
        end else if (acc) begin
            if (col_last) begin
                col_q <= '0; cidx_q <= '0; col_ph_q <= '0;
                if (row_last) begin
                    row_q <= '0; ridx_q <= '0; row_ph_q <= '0;
                end else begin
                    row_q <= row_q + RW'(1);
                    if (row_in) begin
                        if (row_ph_q == PW'(STRIDE - 1)) begin
                            row_ph_q <= '0;
                            ridx_q   <= ridx_q + RW'(1);
                        end else begin
                            row_ph_q <= row_ph_q + PW'(1);
                        end
                    end
                end
            end else begin
                col_q <= col_q + CW'(1);
                if (col_in) begin
                    if (col_ph_q == PW'(STRIDE - 1)) begin
                        col_ph_q <= '0;
                        cidx_q   <= cidx_q + CW'(1);
                    end else begin
                        col_ph_q <= col_ph_q + PW'(1);
                    end
                end
            end
        end
    end

    // A qualifying accept can only happen when no window is pending or the pending one leaves now.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wv_q      <= 1'b0;
            win_row_q <= '0;
            win_col_q <= '0;
        end else if (qual) begin
            wv_q      <= 1'b1;
            win_row_q <= ridx_q;
            win_col_q <= cidx_q;
        end else if (wv_q & bus.win_ready) begin
            wv_q      <= 1'b0;
        end
    end

    assign bus.busy         = (state_q != IDLE);
    assign bus.in_ready     = in_ready;
    assign bus.lb_shift_en  = acc;
    assign bus.window_valid = wv_q;
    assign bus.win_row      = win_row_q;
    assign bus.win_col      = win_col_q;
    assign bus.frame_done   = (state_q == DONE);
endmodule

// File: tb/tb_conv2d_window_scheduler.sv
// Directed bench for the conv2d window scheduler: S=1 and S=2 instances share stimulus through a selector.
module tb_conv2d_window_scheduler;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic start = 1'b0, in_valid = 1'b0, win_ready = 1'b0, sel = 1'b0;
    int n_chk = 0, n_err = 0;

    conv2d_window_scheduler_if #(.CW(3), .RW(3)) b1();
    conv2d_window_scheduler_if #(.CW(3), .RW(3)) b2();

    conv2d_window_scheduler #(.STRIDE(1)) u_s1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
    conv2d_window_scheduler #(.STRIDE(2)) u_s2 (.clk(clk), .rst_n(rst_n), .bus(b2.slave));

    assign b1.start = start & ~sel;
    assign b2.start = start & sel;
    assign b1.in_valid = in_valid;
    assign b2.in_valid = in_valid;
    assign b1.win_ready = win_ready;
    assign b2.win_ready = win_ready;

    logic busy, in_ready, shift, wv, fdone;
    logic [2:0] wrow, wcol;
    assign busy     = sel ? b2.busy         : b1.busy;
    assign in_ready = sel ? b2.in_ready     : b1.in_ready;
    assign shift    = sel ? b2.lb_shift_en  : b1.lb_shift_en;
    assign wv       = sel ? b2.window_valid : b1.window_valid;
    assign wrow     = sel ? b2.win_row      : b1.win_row;
    assign wcol     = sel ? b2.win_col      : b1.win_col;
    assign fdone    = sel ? b2.frame_done   : b1.frame_done;

    typedef struct {
        bit st, iv, wr;
        bit e_busy, e_rdy, e_sh, e_wv;
        int e_r, e_c;
    } vec_t;
    vec_t tbl[34];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic run_frame(input bit s, input bit rnd, input bit mid_start, input string tag);
        int ow, nexp, nwin, acc, first_acc, fd_cyc, last_win_cyc;
        bit busy_drop, bp_bad, sh_bad, hold_pend, done;
        logic [2:0] hr, hc;
        ow = s ? 3 : 6;
        nexp = s ? 6 : 24;
        nwin = 0; acc = 0; first_acc = -1; fd_cyc = -1; last_win_cyc = -1;
        busy_drop = 0; bp_bad = 0; sh_bad = 0; hold_pend = 0; done = 0; hr = '0; hc = '0;
        sel = s;
        start = 1'b1; in_valid = 1'b0; win_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
            in_valid  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            win_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            start     = mid_start && (cyc == 10);
            @(negedge clk);
            if (hold_pend) begin
                chk({tag, " hold valid"}, wv, 1);
                chk({tag, " hold coord"}, {wrow, wcol}, {hr, hc});
            end
            hold_pend = 0;
            if (!busy) busy_drop = 1;
            if (wv && !win_ready && in_ready) bp_bad = 1;
            if (shift !== (in_valid & in_ready)) sh_bad = 1;
            if (wv && first_acc < 0) first_acc = acc;
            if (wv && win_ready) begin
                chk({tag, " win coord"}, {wrow, wcol}, {3'(nwin / ow), 3'(nwin % ow)});
                nwin++;
                last_win_cyc = cyc;
            end else if (wv) begin
                hold_pend = 1; hr = wrow; hc = wcol;
            end
            if (shift) acc++;
            if (fdone) begin
                done = 1;
                fd_cyc = cyc;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        chk({tag, " frame_done seen"}, done, 1);
        chk({tag, " windows"}, nwin, nexp);
        chk({tag, " pixels"}, acc, 48);
        chk({tag, " first window after accepts"}, first_acc, 19);
        chk({tag, " busy held"}, busy_drop, 0);
        chk({tag, " backpressure stalls"}, bp_bad, 0);
        chk({tag, " shift_en"}, sh_bad, 0);
        if (s == 1'b0) chk({tag, " done after last win"}, fd_cyc, last_win_cyc + 1);
        @(negedge clk);
        chk({tag, " idle after done"}, busy, 0);
        chk({tag, " done one pulse"}, fdone, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        int nwin, e, acc;
        bit done, fd_seen;

        for (int i = 0; i < 34; i++)
            tbl[i] = '{st: 0, iv: 1, wr: 1, e_busy: 1, e_rdy: 1, e_sh: 1, e_wv: 0, e_r: 0, e_c: 0};
        tbl[0] = '{st: 1, iv: 0, wr: 1, e_busy: 0, e_rdy: 0, e_sh: 0, e_wv: 0, e_r: 0, e_c: 0};
        for (int i = 20; i < 25; i++)
            tbl[i] = '{st: 0, iv: 1, wr: 0, e_busy: 1, e_rdy: 0, e_sh: 0, e_wv: 1, e_r: 0, e_c: 0};
        for (int i = 25; i < 31; i++) begin
            tbl[i].e_wv = 1;
            tbl[i].e_c  = i - 25;
        end
        tbl[31].e_c = 5;
        tbl[32].e_c = 5;
        tbl[33].e_wv = 1; tbl[33].e_r = 1;

        #12;
        chk("reset busy", busy, 0);
        chk("reset in_ready", in_ready, 0);
        chk("reset window_valid", wv, 0);
        chk("reset frame_done", fdone, 0);
        chk("reset win_row/col", {wrow, wcol}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Stride 1 frame with five stalled cycles on the first window.
        nwin = 0;
        for (int i = 0; i < 34; i++) begin
            start = tbl[i].st; in_valid = tbl[i].iv; win_ready = tbl[i].wr;
            @(negedge clk);
            chk($sformatf("tbl%0d busy", i), busy, tbl[i].e_busy);
            chk($sformatf("tbl%0d in_ready", i), in_ready, tbl[i].e_rdy);
            chk($sformatf("tbl%0d shift_en", i), shift, tbl[i].e_sh);
            chk($sformatf("tbl%0d window_valid", i), wv, tbl[i].e_wv);
            chk($sformatf("tbl%0d win_row", i), wrow, tbl[i].e_r);
            chk($sformatf("tbl%0d win_col", i), wcol, tbl[i].e_c);
            if (wv && win_ready) nwin++;
            @(posedge clk); #1;
        end
        start = 1'b0;
        chk("tbl windows so far", nwin, 7);
        e = nwin; done = 0;
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            in_valid = 1'b1; win_ready = 1'b1;
            @(negedge clk);
            if (wv && win_ready) begin
                chk("bp win coord", {wrow, wcol}, {3'(e / 6), 3'(e % 6)});
                e++;
            end
            if (fdone) done = 1;
            @(posedge clk); #1;
        end
        chk("bp frame_done seen", done, 1);
        chk("bp total windows", e, 24);
        @(posedge clk); #1;

        run_frame(1'b0, 1'b0, 1'b0, "s1");
        run_frame(1'b1, 1'b0, 1'b0, "s2");
        run_frame(1'b0, 1'b1, 1'b0, "s1 rand");
        run_frame(1'b1, 1'b1, 1'b0, "s2 rand");
        run_frame(1'b0, 1'b0, 1'b1, "s1 midstart");

        // Abort a frame with reset after 30 accepted pixels.
        sel = 1'b0; acc = 0; fd_seen = 0;
        start = 1'b1; in_valid = 1'b0; win_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int cyc = 0; cyc < 200 && acc < 30; cyc++) begin
            in_valid = 1'b1;
            @(negedge clk);
            if (shift) acc++;
            if (fdone) fd_seen = 1;
            @(posedge clk); #1;
        end
        chk("abort pixels", acc, 30);
        chk("abort window pending", wv, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("abort busy", busy, 0);
        chk("abort in_ready", in_ready, 0);
        chk("abort shift_en", shift, 0);
        chk("abort window_valid", wv, 0);
        chk("abort win_row/col", {wrow, wcol}, 0);
        chk("abort frame_done", fdone | fd_seen, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        run_frame(1'b0, 1'b0, 1'b0, "after reset");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
